jk_mod_counter: RTL and testbench
=================================

Name: jk_mod_counter

Overview:
- Parametrised synchronous modulo up/down counter built from a bank of WIDTH JK cells.
- Next generation of the lab single-bit JK flip-flop: generalised to width, modulus and mode control.
- Used as the general-purpose counter/timer primitive in later labs (clock dividers, sequencers).
- Falling-edge clocked, like the existing JK flip-flop.

Parameters:
- WIDTH, 4: counter width in bits; legal range 2..16.
- MODULUS, 10: count range is 0..MODULUS-1; legal range 2..2**WIDTH; elaboration error otherwise.

Ports:
- clk  input  1  clock; all state updates on the falling edge.
- reset  input  1  reset, asynchronous, active-low.
- mode  input  2  operation select: 00 HOLD, 01 COUNT, 10 LOAD, 11 CLEAR.
- up  input  1  count direction in COUNT mode: 1 up, 0 down.
- d  input  WIDTH  load value used in LOAD mode.
- q  output  WIDTH  current count.
- tc  output  1  terminal count (combinational).
- load_err  output  1  sticky flag: an out-of-range load was attempted.

Behaviour:
- Reset asserted (reset=0), immediately and regardless of clk: q=0, load_err=0. Reset can land mid-count or mid-load; no partial update survives it.
- Reset release: the first falling edge with reset=1 performs a normal update. No extra latency.
- Falling-edge updates, with reset deasserted:
  - HOLD: q unchanged.
  - COUNT, up=1: q=q+1; if q==MODULUS-1 then q=0 (wrap).
  - COUNT, up=0: q=q-1; if q==0 then q=MODULUS-1 (wrap).
  - LOAD: if d<MODULUS then q=d. Otherwise q=MODULUS-1 and load_err=1.
  - CLEAR: q=0 and load_err=0.
- load_err is changed only by LOAD, CLEAR and reset; it holds its value otherwise.
- Per-bit JK drive:
  - HOLD: j=k=0.
  - COUNT: j=k=toggle_i, computed from the next-count value so that wrap is handled.
  - LOAD/CLEAR: j=next_i, k=~next_i.
  - Next-state logic must be expressible as JK inputs only; no direct D assignment to q.
- tc = (mode==COUNT) & ((up & q==MODULUS-1) | (~up & q==0)). It is combinational and valid before the edge on which the wrap occurs.
- Latency: q reflects a command one falling edge after it is sampled.
- Boundary cases:
  - MODULUS==2**WIDTH: wrap is natural binary overflow; load_err can never set.
  - q is never allowed to hold a value ≥ MODULUS.
  - A direction change mid-count takes effect on the next edge with no glitch cycle.

Optional Feature:
- Macro: JK_MOD_COUNTER_SATURATE_EN.
- When defined, COUNT saturates instead of wrapping: up at MODULUS-1 holds MODULUS-1; down at 0 holds 0. tc still asserts in those states.
- When undefined, wrap behaviour as described above.

Decomposition:
- Package jk_pkg:
  - typedef enum logic [1:0] jk_mode_t {JK_HOLD, JK_COUNT, JK_LOAD, JK_CLEAR}.
  - Constant JK_MAX_WIDTH=16.
- Sub-module jk_cell: one-bit JK flip-flop with j, k, clk, reset (async active-low), q. Falling-edge clocked; q+ = j&~q | ~k&q.
- Top level: instantiate WIDTH jk_cell instances in a generate loop, plus the next-state/JK-drive combinational block and the load_err register.

Test Plan (WIDTH=4, MODULUS=10, wrap build unless stated):
- Reset, then COUNT up=1 for 12 falling edges -> q sequence 1..9,0,1,2; tc=1 only while q==9.
- LOAD d=7, then COUNT up=0 for 9 edges -> q=7,6,...,0,9,8; tc=1 while q==0.
- LOAD d=12 -> q=9, load_err=1. HOLD for 3 edges -> q=9, load_err=1. CLEAR -> q=0, load_err=0.
- COUNT up=1 to q=5, pull reset low between edges -> q=0 immediately, with no wait for clk. Release reset -> next edge q=1.
- HOLD for 5 edges from q=3 -> q stays 3; toggle up with mode=COUNT -> next edge q=4, following edge (up=0) q=3.
- JK_MOD_COUNTER_SATURATE_EN defined: from q=8 COUNT up for 4 edges -> 9,9,9,9; from q=1 COUNT down for 3 edges -> 0,0,0.

Source files
------------

// File: rtl/jk_pkg.sv
// Package jk_pkg: shared types and limits for the JK-based modulo counter.
//   jk_mode_t    : 2-bit operation select (HOLD, COUNT, LOAD, CLEAR)
//   JK_MAX_WIDTH : widest counter the design accepts
package jk_pkg;

   typedef enum logic [1:0] {
      JK_HOLD  = 2'b00,
      JK_COUNT = 2'b01,
      JK_LOAD  = 2'b10,
      JK_CLEAR = 2'b11
   } jk_mode_t;

   localparam int JK_MAX_WIDTH = 16;

endpackage : jk_pkg

// File: rtl/jk_cell.sv
// jk_cell: single-bit JK flip-flop, falling-edge clocked.
//   clk   : clock, state changes on the falling edge
//   reset : asynchronous, active-low; forces q to 0
//   j, k  : JK inputs, q+ = j&~q | ~k&q
//   q     : stored bit
module jk_cell (
   input  logic clk,
   input  logic reset,
   input  logic j,
   input  logic k,
   output logic q
);

   // NOTE: clocked state uses non-blocking assignments so every cell in the
   // bank samples the pre-edge value of its neighbours' outputs.
   always_ff @(negedge clk or negedge reset) begin
      if (!reset) q <= 1'b0;
      else        q <= (j & ~q) | (~k & q);
   end

endmodule : jk_cell

// File: rtl/jk_mod_counter.sv
// jk_mod_counter: synchronous modulo up/down counter built from WIDTH JK cells.
//   clk      : clock, all updates on the falling edge
//   reset    : asynchronous, active-low; q=0, load_err=0
//   mode     : 00 HOLD, 01 COUNT, 10 LOAD, 11 CLEAR
//   up       : count direction in COUNT mode (1 up, 0 down)
//   d        : load value for LOAD mode
//   q        : current count, always in 0..MODULUS-1
//   tc       : terminal count, combinational, high in COUNT mode at the wrap point
//   load_err : sticky flag, set by an out-of-range LOAD, cleared by CLEAR/reset
// Build option: define JK_MOD_COUNTER_SATURATE_EN to make COUNT saturate at
// the ends of the range instead of wrapping.
module jk_mod_counter
   import jk_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       mode,
   input  logic             up,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             load_err
);

   // Parameter legality is checked at elaboration.
   if (WIDTH < 2 || WIDTH > JK_MAX_WIDTH) begin : g_bad_width
      $error("jk_mod_counter: WIDTH=%0d outside 2..%0d", WIDTH, JK_MAX_WIDTH);
   end
   if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
      $error("jk_mod_counter: MODULUS=%0d outside 2..2**WIDTH", MODULUS);
   end

   localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);
   // One bit wider so MODULUS==2**WIDTH is representable in the load compare.
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

   jk_mode_t         mode_e;
   logic             at_max;
   logic             at_zero;
   logic             load_ok;
   logic [WIDTH-1:0] count_next;
   logic [WIDTH-1:0] next_q;
   logic [WIDTH-1:0] j;
   logic [WIDTH-1:0] k;
   logic             err_next;

   assign mode_e  = jk_mode_t'(mode);
   assign at_max  = (q == MAX_Q);
   assign at_zero = (q == '0);
   assign load_ok = ({1'b0, d} < MOD_EXT);

   // Next count value, with the range ends resolved here so the JK drive
   // below only has to express the bit changes.
`ifdef JK_MOD_COUNTER_SATURATE_EN
   assign count_next = up ? (at_max  ? MAX_Q : q + WIDTH'(1))
                          : (at_zero ? '0    : q - WIDTH'(1));
`else
   assign count_next = up ? (at_max  ? '0    : q + WIDTH'(1))
                          : (at_zero ? MAX_Q : q - WIDTH'(1));
`endif

   // NOTE: every output of this block gets a default first, so no path
   // through the case leaves a signal unassigned and no latch is inferred.
   always_comb begin
      next_q   = q;
      j        = '0;
      k        = '0;
      err_next = load_err;
      unique case (mode_e)
         JK_HOLD: begin
            next_q = q;
         end
         JK_COUNT: begin
            // Toggle exactly the bits that differ between q and its successor.
            next_q = count_next;
            j      = q ^ count_next;
            k      = q ^ count_next;
         end
         JK_LOAD: begin
            next_q = load_ok ? d : MAX_Q;
            j      = next_q;
            k      = ~next_q;
            if (!load_ok) err_next = 1'b1;
         end
         JK_CLEAR: begin
            next_q   = '0;
            j        = next_q;
            k        = ~next_q;
            err_next = 1'b0;
         end
         default: begin
            next_q = q;
         end
      endcase
   end

   assign tc = (mode_e == JK_COUNT) & (up ? at_max : at_zero);

   always_ff @(negedge clk or negedge reset) begin
      if (!reset) load_err <= 1'b0;
      else        load_err <= err_next;
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      jk_cell u_cell (
         .clk   (clk),
         .reset (reset),
         .j     (j[i]),
         .k     (k[i]),
         .q     (q[i])
      );
   end

endmodule : jk_mod_counter

// File: tb/tb_jk_mod_counter.sv
// Self-checking bench for jk_mod_counter (WIDTH=4, MODULUS=10).
// A plain-arithmetic model tracks the count; a compare process checks q, tc
// and load_err against it on every rising edge (mid-cycle), and directed
// steps check hand-computed literal values.
module tb_jk_mod_counter;
   import jk_pkg::*;

   localparam int W = 4;
   localparam int M = 10;

   logic         clk;
   logic         reset;
   logic [1:0]   mode;
   logic         up;
   logic [W-1:0] d;
   logic [W-1:0] q;
   logic         tc;
   logic         load_err;

   int errors = 0;
   int checks = 0;

   int model_q   = 0;
   int model_err = 0;
   bit cmp_en    = 1'b0;

   jk_mod_counter #(.WIDTH(W), .MODULUS(M)) dut (
      .clk      (clk),
      .reset    (reset),
      .mode     (mode),
      .up       (up),
      .d        (d),
      .q        (q),
      .tc       (tc),
      .load_err (load_err)
   );

   initial clk = 1'b1;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at t=%0t", name, actual, expected, $time);
      end
   endtask

   // Behavioural model: range arithmetic straight from the operation rules.
   always @(negedge clk or negedge reset) begin
      if (!reset) begin
         model_q   = 0;
         model_err = 0;
      end else begin
         case (int'(mode))
            1: begin
`ifdef JK_MOD_COUNTER_SATURATE_EN
               if (up) model_q = (model_q == M - 1) ? model_q : model_q + 1;
               else    model_q = (model_q == 0)     ? 0       : model_q - 1;
`else
               if (up) model_q = (model_q + 1) % M;
               else    model_q = (model_q + M - 1) % M;
`endif
            end
            2: begin
               if (int'(d) < M) model_q = int'(d);
               else begin
                  model_q   = M - 1;
                  model_err = 1;
               end
            end
            3: begin
               model_q   = 0;
               model_err = 0;
            end
            default: ;
         endcase
      end
   end

   // Mid-cycle compare against the model.
   always @(posedge clk) begin
      if (cmp_en) begin
         check("cyc_q", 32'(q), 32'(model_q));
         check("cyc_err", 32'(load_err), 32'(model_err));
         check("cyc_tc", 32'(tc),
               32'((mode == 2'b01) && (up ? (model_q == M - 1) : (model_q == 0))));
      end
   end

   // Drive a command, let one falling edge take it, settle 2 time units after.
   task automatic apply(input jk_mode_t m, input logic u, input logic [W-1:0] dv);
      mode = m;
      up   = u;
      d    = dv;
      @(negedge clk);
      #2;
   endtask

   initial begin
      int exp_up[12];
      int exp_dn[9];
      int exp_sat_up[4];
      int exp_sat_dn[3];

`ifdef JK_MOD_COUNTER_SATURATE_EN
      exp_up     = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 9, 9, 9};
      exp_dn     = '{6, 5, 4, 3, 2, 1, 0, 0, 0};
      exp_sat_up = '{9, 9, 9, 9};
      exp_sat_dn = '{0, 0, 0};
`else
      exp_up     = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
      exp_dn     = '{6, 5, 4, 3, 2, 1, 0, 9, 8};
      exp_sat_up = '{9, 0, 1, 2};
      exp_sat_dn = '{0, 9, 8};
`endif

      reset = 1'b0;
      mode  = JK_HOLD;
      up    = 1'b1;
      d     = '0;
      @(negedge clk);
      #2;
      check("reset_q", 32'(q), 0);
      check("reset_err", 32'(load_err), 0);
      reset  = 1'b1;
      cmp_en = 1'b1;

      // Count up 12 edges; tc only while q==9 (up).
      for (int i = 0; i < 12; i++) begin
         mode = JK_COUNT;
         up   = 1'b1;
         #1;
         check("up_tc", 32'(tc), 32'(q == 4'd9));
         apply(JK_COUNT, 1'b1, '0);
         check("up_q", 32'(q), 32'(exp_up[i]));
      end

      // Load 7, count down 9 edges; tc while q==0 (down).
      apply(JK_LOAD, 1'b0, 4'd7);
      check("load7_q", 32'(q), 7);
      check("load7_err", 32'(load_err), 0);
      for (int i = 0; i < 9; i++) begin
         mode = JK_COUNT;
         up   = 1'b0;
         #1;
         check("dn_tc", 32'(tc), 32'(q == 4'd0));
         apply(JK_COUNT, 1'b0, '0);
         check("dn_q", 32'(q), 32'(exp_dn[i]));
      end

      // Out-of-range load, hold, clear.
      apply(JK_LOAD, 1'b0, 4'd12);
      check("bad_load_q", 32'(q), 9);
      check("bad_load_err", 32'(load_err), 1);
      for (int i = 0; i < 3; i++) begin
         apply(JK_HOLD, 1'b1, 4'd3);
         check("hold_q", 32'(q), 9);
         check("hold_err", 32'(load_err), 1);
      end
      // A valid load leaves the sticky flag set.
      apply(JK_LOAD, 1'b1, 4'd9);
      check("sticky_err", 32'(load_err), 1);
      apply(JK_CLEAR, 1'b1, 4'd5);
      check("clear_q", 32'(q), 0);
      check("clear_err", 32'(load_err), 0);

      // Set the flag again, count up to 5, then reset between edges.
      apply(JK_LOAD, 1'b1, 4'd15);
      check("load15_q", 32'(q), 9);
      check("load15_err", 32'(load_err), 1);
      for (int i = 0; i < 6; i++) apply(JK_COUNT, 1'b1, '0);
      check("pre_reset_q", 32'(q), 5);
      reset = 1'b0;
      #1;
      check("async_reset_q", 32'(q), 0);
      check("async_reset_err", 32'(load_err), 0);
      #5;
      reset = 1'b1;
      @(negedge clk);
      #2;
      check("post_reset_q", 32'(q), 1);

      // Hold at 3, then direction change mid-count.
      apply(JK_COUNT, 1'b1, '0);
      apply(JK_COUNT, 1'b1, '0);
      check("to3_q", 32'(q), 3);
      for (int i = 0; i < 5; i++) begin
         apply(JK_HOLD, 1'b0, 4'd8);
         check("hold3_q", 32'(q), 3);
      end
      apply(JK_COUNT, 1'b1, '0);
      check("dir_up_q", 32'(q), 4);
      apply(JK_COUNT, 1'b0, '0);
      check("dir_dn_q", 32'(q), 3);

      // Range ends: saturate build holds, wrap build rolls over.
      apply(JK_LOAD, 1'b1, 4'd8);
      for (int i = 0; i < 4; i++) begin
         apply(JK_COUNT, 1'b1, '0);
         check("end_up_q", 32'(q), 32'(exp_sat_up[i]));
      end
      apply(JK_LOAD, 1'b0, 4'd1);
      for (int i = 0; i < 3; i++) begin
         apply(JK_COUNT, 1'b0, '0);
         check("end_dn_q", 32'(q), 32'(exp_sat_dn[i]));
      end

      apply(JK_HOLD, 1'b1, '0);
      cmp_en = 1'b0;
      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_jk_mod_counter
